// File: rtl/vram_write_arbiter.sv
// VRAM write-port owner: arbitrates CPU single writes against a rectangle fill
// engine, strictly alternating when both want the port on the same edge.
module vram_write_arbiter #(
  parameter int STRIDE = 480,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  output logic          cpu_ack,
  input  logic          fill_start,
  input  logic [9:0]    fill_x,
  input  logic [9:0]    fill_y,
  input  logic [9:0]    fill_w,
  input  logic [9:0]    fill_h,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] vram_write_addr,
  output logic [DW-1:0] vram_write_data,
  output logic          vram_write_en
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam logic [AW-1:0] STRIDE_W = AW'(STRIDE);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] row_base;
  logic [AW-1:0] row_base_nx;
  logic [AW-1:0] start_base;
  logic [9:0]    col;
  logic [9:0]    col_nx;
  logic [9:0]    row;
  logic [9:0]    row_nx;
  logic [9:0]    w_q;
  logic [9:0]    h_q;
  logic [DW-1:0] color;
  logic          load;
  logic          last_fill;
  logic          cpu_elig;
  logic          fill_elig;
  logic          gnt_cpu;
  logic          gnt_fill;

  // Single multiply, only used when a fill is latched.
  assign start_base = AW'(32'(fill_y) * 32'(STRIDE) + 32'(fill_x));

  // The registered ack masks the still-high request for one cycle.
  assign cpu_elig  = cpu_req & ~cpu_ack;
  assign fill_elig = (state == FILL);
  assign gnt_cpu   = cpu_elig & (~fill_elig | last_fill);
  assign gnt_fill  = fill_elig & (~cpu_elig | ~last_fill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    col_nx      = col;
    row_nx      = row;
    row_base_nx = row_base;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill_start) begin
          load        = 1'b1;
          col_nx      = '0;
          row_nx      = '0;
          row_base_nx = start_base;
          if (fill_w == '0 || fill_h == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = FILL;
          end
        end
      end
      FILL: begin
        if (gnt_fill) begin
          if (col == w_q - 10'd1) begin
            col_nx      = '0;
            row_nx      = row + 10'd1;
            row_base_nx = row_base + STRIDE_W;
            if (row == h_q - 10'd1) begin
              state_nx = DONE;
            end
          end else begin
            col_nx = col + 10'd1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      col      <= '0;
      row      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color    <= '0;
    end else begin
      row_base <= row_base_nx;
      col      <= col_nx;
      row      <= row_nx;
      if (load) begin
        w_q   <= fill_w;
        h_q   <= fill_h;
        color <= fill_color;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_fill <= 1'b1;
    end else if (gnt_cpu) begin
      last_fill <= 1'b0;
    end else if (gnt_fill) begin
      last_fill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_write_en   <= 1'b0;
      vram_write_addr <= '0;
      vram_write_data <= '0;
      cpu_ack         <= 1'b0;
    end else if (gnt_cpu) begin
      vram_write_en   <= 1'b1;
      vram_write_addr <= cpu_addr;
      vram_write_data <= cpu_data;
      cpu_ack         <= 1'b1;
    end else if (gnt_fill) begin
      vram_write_en   <= 1'b1;
      vram_write_addr <= row_base + AW'(col);
      vram_write_data <= color;
      cpu_ack         <= 1'b0;
    end else begin
      vram_write_en   <= 1'b0;
      cpu_ack         <= 1'b0;
    end
  end

  // Busy rises with the latch edge and falls together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_busy <= (state_nx != IDLE) | (state == DONE);
      fill_done <= (state == DONE);
    end
  end

endmodule
